// File: rtl/multi_tone_oscillator.sv
// Multi-channel square-wave tone generator with timed notes, rests and sustain.
// Define MULTI_TONE_MIX_REG_EN to register the mixer output (one-cycle lag).
module multi_tone_oscillator #(
   parameter  int NCH   = 4,
   parameter  int WIDTH = 16,
   parameter  int DUR_W = 12,
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int MW    = $clog2(NCH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   chEnable,
   input  logic             load,
   input  logic [CW-1:0]    loadCh,
   input  logic [WIDTH-1:0] loadPeriod,
   input  logic [DUR_W-1:0] loadDuration,
   input  logic             tick,
   output logic [NCH-1:0]   toneOut,
   output logic [NCH-1:0]   busy,
   output logic [NCH-1:0]   done,
   output logic [MW-1:0]    mixOut
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [WIDTH-1:0] P_ONE = WIDTH'(1);
   localparam logic [DUR_W-1:0] D_ONE = DUR_W'(1);

   state_e           state_q  [NCH];
   state_e           state_d  [NCH];
   logic [WIDTH-1:0] period_q [NCH];
   logic [WIDTH-1:0] period_d [NCH];
   logic [WIDTH-1:0] count_q  [NCH];
   logic [WIDTH-1:0] count_d  [NCH];
   logic [DUR_W-1:0] dur_q    [NCH];
   logic [DUR_W-1:0] dur_d    [NCH];
   logic [NCH-1:0]   tone_q;
   logic [NCH-1:0]   tone_d;
   logic [NCH-1:0]   done_q;
   logic [NCH-1:0]   done_d;
   logic [NCH-1:0]   load_hit;
   logic [MW-1:0]    pop;

   // An out-of-range loadCh simply matches no channel.
   always_comb begin
      load_hit = '0;
      for (int c = 0; c < NCH; c++) begin
         load_hit[c] = load && (int'(loadCh) == c);
      end
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         state_d[c]  = state_q[c];
         period_d[c] = period_q[c];
         count_d[c]  = count_q[c];
         dur_d[c]    = dur_q[c];
         tone_d[c]   = tone_q[c];
         done_d[c]   = 1'b0;
         // Priority: disable, then load, then expiry, then phase.
         if (!chEnable[c]) begin
            state_d[c] = IDLE;
            count_d[c] = '0;
            tone_d[c]  = 1'b0;
         end else if (load_hit[c]) begin
            state_d[c]  = RUN;
            period_d[c] = loadPeriod;
            dur_d[c]    = loadDuration;
            count_d[c]  = '0;
            tone_d[c]   = 1'b0;
         end else if (state_q[c] == RUN) begin
            if (tick && dur_q[c] != '0) begin
               dur_d[c] = dur_q[c] - D_ONE;
            end
            if (tick && dur_q[c] == D_ONE) begin
               state_d[c] = IDLE;
               count_d[c] = '0;
               tone_d[c]  = 1'b0;
               done_d[c]  = 1'b1;
            end else if (period_q[c] == '0) begin
               count_d[c] = '0;
               tone_d[c]  = 1'b0;
            end else if (count_q[c] == period_q[c] - P_ONE) begin
               count_d[c] = '0;
               tone_d[c]  = ~tone_q[c];
            end else begin
               count_d[c] = count_q[c] + P_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            state_q[c]  <= IDLE;
            period_q[c] <= '0;
            count_q[c]  <= '0;
            dur_q[c]    <= '0;
         end
         tone_q <= '0;
         done_q <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            state_q[c]  <= state_d[c];
            period_q[c] <= period_d[c];
            count_q[c]  <= count_d[c];
            dur_q[c]    <= dur_d[c];
         end
         tone_q <= tone_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      pop = '0;
      for (int c = 0; c < NCH; c++) begin
         pop = pop + MW'(tone_q[c]);
      end
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         busy[c] = (state_q[c] == RUN);
      end
   end

   assign toneOut = tone_q;
   assign done    = done_q;

`ifdef MULTI_TONE_MIX_REG_EN
   logic [MW-1:0] mix_q;
   logic [MW-1:0] mix_d;

   always_comb mix_d = pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mix_q <= '0;
      end else begin
         mix_q <= mix_d;
      end
   end

   assign mixOut = mix_q;
`else
   assign mixOut = pop;
`endif

endmodule

// File: tb/tb_multi_tone_oscillator.sv
// Randomized and directed bench for multi_tone_oscillator against an
// elapsed-time reference model.
module tb_multi_tone_oscillator;

   localparam int NCH   = 4;
   localparam int WIDTH = 16;
   localparam int DUR_W = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   chEnable = '0;
   logic             load = 1'b0;
   logic [1:0]       loadCh = '0;
   logic [WIDTH-1:0] loadPeriod = '0;
   logic [DUR_W-1:0] loadDuration = '0;
   logic             tick = 1'b0;
   logic [NCH-1:0]   toneOut;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   done;
   logic [2:0]       mixOut;

   logic [2:0]       chEnable3 = '0;
   logic             load3 = 1'b0;
   logic [1:0]       loadCh3 = '0;
   logic [2:0]       toneOut3;
   logic [2:0]       busy3;
   logic [2:0]       done3;
   logic [1:0]       mixOut3;

   multi_tone_oscillator #(.NCH(NCH), .WIDTH(WIDTH), .DUR_W(DUR_W)) u_dut (
      .clk(clk), .rst(rst), .chEnable(chEnable), .load(load),
      .loadCh(loadCh), .loadPeriod(loadPeriod),
      .loadDuration(loadDuration), .tick(tick), .toneOut(toneOut),
      .busy(busy), .done(done), .mixOut(mixOut)
   );

   multi_tone_oscillator #(.NCH(3), .WIDTH(WIDTH), .DUR_W(DUR_W)) u_dut3 (
      .clk(clk), .rst(rst), .chEnable(chEnable3), .load(load3),
      .loadCh(loadCh3), .loadPeriod(loadPeriod),
      .loadDuration(loadDuration), .tick(tick), .toneOut(toneOut3),
      .busy(busy3), .done(done3), .mixOut(mixOut3)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   // Reference model: time since load decides the wave, ticks left decide expiry.
   bit       act  [NCH];
   int       per  [NCH];
   int       el   [NCH];
   int       left [NCH];
   bit [3:0] tone_e;
   bit [3:0] done_e;
   int       mix_e;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic int pop4(input bit [3:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         act[c] = 0; per[c] = 0; el[c] = 0; left[c] = 0;
      end
      tone_e = '0; done_e = '0; mix_e = 0;
   endtask

   task automatic model_edge(input logic [3:0] en, input logic ld,
                             input logic [1:0] ch, input int p,
                             input int d, input logic tk);
      int prev;
      prev = pop4(tone_e);
      for (int c = 0; c < NCH; c++) begin
         done_e[c] = 1'b0;
         if (!en[c]) begin
            act[c] = 0;
         end else if (ld && int'(ch) == c) begin
            act[c] = 1; per[c] = p; el[c] = 0; left[c] = d;
         end else if (act[c]) begin
            if (tk && left[c] > 0) begin
               left[c]--;
               if (left[c] == 0) begin
                  act[c] = 0;
                  done_e[c] = 1'b1;
               end
            end
            if (act[c]) el[c]++;
         end
         tone_e[c] = act[c] && per[c] != 0 && ((el[c] / per[c]) % 2 == 1);
      end
`ifdef MULTI_TONE_MIX_REG_EN
      mix_e = prev;
`else
      mix_e = pop4(tone_e);
`endif
   endtask

   task automatic compare_all(input string tag);
      bit [3:0] busy_e;
      for (int c = 0; c < NCH; c++) busy_e[c] = act[c];
      check({tag, ".tone"}, 32'(toneOut), 32'(tone_e));
      check({tag, ".busy"}, 32'(busy), 32'(busy_e));
      check({tag, ".done"}, 32'(done), 32'(done_e));
      check({tag, ".mix"}, 32'(mixOut), 32'(mix_e));
   endtask

   task automatic step(input string tag, input logic [3:0] en,
                       input logic ld, input logic [1:0] ch,
                       input int p, input int d, input logic tk);
      chEnable = en; load = ld; loadCh = ch;
      loadPeriod = WIDTH'(p); loadDuration = DUR_W'(d); tick = tk;
      @(posedge clk);
      model_edge(en, ld, ch, p, d, tk);
      #1;
      compare_all(tag);
      load = 1'b0; tick = 1'b0;
   endtask

   task automatic idle(input string tag, input logic [3:0] en,
                       input int n, input int tick_every);
      for (int i = 1; i <= n; i++) begin
         step(tag, en, 1'b0, 2'd0, 0, 0,
              (tick_every > 0) && (i % tick_every == 0));
      end
   endtask

   initial begin
      model_reset();
      #2;
      check("rst.tone", 32'(toneOut), 32'(0));
      check("rst.busy", 32'(busy), 32'(0));
      check("rst.done", 32'(done), 32'(0));
      check("rst.mix", 32'(mixOut), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Sustained tone on ch0, period 6.
      step("ch0.load", 4'b0001, 1'b1, 2'd0, 3, 0, 1'b0);
      idle("ch0.run", 4'b0001, 20, 7);

      // Timed note on ch1 with sparse ticks.
      step("ch1.load", 4'b0011, 1'b1, 2'd1, 2, 2, 1'b0);
      idle("ch1.run", 4'b0011, 25, 10);

      // Rest on ch2, one tick.
      step("ch2.load", 4'b0111, 1'b1, 2'd2, 0, 1, 1'b0);
      idle("ch2.run", 4'b0111, 5, 0);
      step("ch2.tick", 4'b0111, 1'b0, 2'd0, 0, 0, 1'b1);
      idle("ch2.after", 4'b0111, 3, 0);

      // All channels at P=1, loaded on consecutive cycles.
      for (int c = 0; c < NCH; c++) begin
         step("all.load", 4'b1111, 1'b1, 2'(c), 1, 0, 1'b0);
      end
      idle("all.run", 4'b1111, 6, 0);

      // ch3 collisions: disable beats load, load beats tick.
      step("ch3.load", 4'b1111, 1'b1, 2'd3, 4, 5, 1'b0);
      idle("ch3.run", 4'b1111, 3, 0);
      step("ch3.dis", 4'b0111, 1'b1, 2'd3, 4, 5, 1'b0);
      step("ch3.load2", 4'b1111, 1'b1, 2'd3, 4, 5, 1'b0);
      idle("ch3.ticks", 4'b1111, 8, 2);
      step("ch3.ldtk", 4'b1111, 1'b1, 2'd3, 4, 5, 1'b1);
      idle("ch3.drain", 4'b1111, 14, 2);
      // Load on the very tick that would expire it.
      step("ch3.load3", 4'b1111, 1'b1, 2'd3, 2, 1, 1'b0);
      step("ch3.ldexp", 4'b1111, 1'b1, 2'd3, 2, 1, 1'b1);
      idle("ch3.end", 4'b1111, 4, 4);

      // Out-of-range channel on a 3-channel instance.
      chEnable3 = 3'b111; load3 = 1'b1; loadCh3 = 2'd3;
      step("oor.step", 4'b1111, 1'b0, 2'd0, 5, 0, 1'b0);
      check("oor.busy", 32'(busy3), 32'(0));
      check("oor.tone", 32'(toneOut3), 32'(0));
      loadCh3 = 2'd2;
      step("oor.valid", 4'b1111, 1'b0, 2'd0, 5, 0, 1'b0);
      check("oor.busyok", 32'(busy3), 32'(3'b100));
      load3 = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] en;
         for (int c = 0; c < NCH; c++) begin
            en[c] = ($urandom_range(0, 39) != 0);
         end
         step("rand", en, ($urandom_range(0, 7) == 0),
              2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
      end

      // Asynchronous reset in the middle of notes.
      for (int c = 0; c < NCH; c++) begin
         step("mid.load", 4'b1111, 1'b1, 2'(c), 1, 3, 1'b0);
      end
      idle("mid.run", 4'b1111, 3, 0);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check("mid.tone", 32'(toneOut), 32'(0));
      check("mid.busy", 32'(busy), 32'(0));
      check("mid.done", 32'(done), 32'(0));
      check("mid.mix", 32'(mixOut), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      idle("post", 4'b1111, 4, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
